puzzle_loader: RTL and testbench

- Upstream stage of sudoku_solver.
- Clears solver memory, then accepts 81 puzzle cells over a valid/ready stream in row-major order.
- Writes each cell value and fix flag, sets row/col/matrix marks for given digits, and rejects illegal or conflicting puzzles.
- Pulses start to the solver, then supervises it until done or timeout.

---
 rtl/sudoku_pkg.sv | 30 +++
 rtl/cell_pos_cnt.sv | 70 +++++++
 rtl/puzzle_loader.sv | 216 +++++++++++++++++++++
 tb/tb_puzzle_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants for the sudoku loader/solver pair: geometry, FSM encoding,
// error codes and the mark-table address helper.
package sudoku_pkg;

  localparam int N_CELL = 81;
  localparam int DIG_W  = 4;
  localparam int ADDR_W = 7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_SOLVE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_DUP     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // idx*9 + d - 1, built from a shift and an add.
  function automatic logic [ADDR_W-1:0] mark_addr(input logic [3:0] idx,
                                                  input logic [DIG_W-1:0] d);
    logic [ADDR_W-1:0] base;
    base = ({3'd0, idx} << 3) + {3'd0, idx};
    return base + {3'd0, d} - 7'd1;
  endfunction

endpackage

// File: rtl/cell_pos_cnt.sv
// Row-major cell walker: linear index plus row, column and 3x3 box number,
// all kept as incrementing counters so no divider is needed.
module cell_pos_cnt
  import sudoku_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt,
  output logic [3:0]        row,
  output logic [3:0]        col,
  output logic [3:0]        box,
  output logic              last
);

  logic [1:0] col_sub;
  logic [1:0] row_sub;
  logic [3:0] box_col;
  logic [3:0] box_base;

  // Position counters; box = first box of the band + box column within it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 7'd0;
      row      <= 4'd0;
      col      <= 4'd0;
      col_sub  <= 2'd0;
      row_sub  <= 2'd0;
      box_col  <= 4'd0;
      box_base <= 4'd0;
    end else if (clear || (en && last)) begin
      cnt      <= 7'd0;
      row      <= 4'd0;
      col      <= 4'd0;
      col_sub  <= 2'd0;
      row_sub  <= 2'd0;
      box_col  <= 4'd0;
      box_base <= 4'd0;
    end else if (en) begin
      cnt <= cnt + 7'd1;
      if (col == 4'd8) begin
        col     <= 4'd0;
        col_sub <= 2'd0;
        box_col <= 4'd0;
        row     <= row + 4'd1;
        if (row_sub == 2'd2) begin
          row_sub  <= 2'd0;
          box_base <= box_base + 4'd3;
        end else begin
          row_sub <= row_sub + 2'd1;
        end
      end else begin
        col <= col + 4'd1;
        if (col_sub == 2'd2) begin
          col_sub <= 2'd0;
          box_col <= box_col + 4'd1;
        end else begin
          col_sub <= col_sub + 2'd1;
        end
      end
    end else begin
      cnt <= cnt;
    end
  end

  assign box  = box_base + box_col;
  assign last = (cnt == 7'(N_CELL - 1));

endmodule

// File: rtl/puzzle_loader.sv
// Front end of the sudoku solver: clears solver memory, streams in 81 cells,
// rejects illegal/conflicting givens, then starts and supervises the solver.
module puzzle_loader
  import sudoku_pkg::*;
#(
  parameter logic [31:0] MAX_SOLVE_CYCLES = 32'd10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_begin,
  input  logic              i_load_valid,
  input  logic [DIG_W-1:0]  i_load_data,
  output logic              o_load_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DIG_W-1:0]  o_wrdata,
  output logic              o_mark_fix,
  output logic              o_we_mark,
  output logic              o_mark_value,
  output logic [ADDR_W-1:0] o_addr_mark_row,
  output logic [ADDR_W-1:0] o_addr_mark_col,
  output logic [ADDR_W-1:0] o_addr_mark_matrix,
  output logic              o_start,
  input  logic              i_solver_done,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_error
);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [31:0]       tcnt;
  logic [ADDR_W-1:0] cnt;
  logic [3:0]        row;
  logic [3:0]        col;
  logic [3:0]        box;
  logic              last;
  logic [8:0]        row_map [9];
  logic [8:0]        col_map [9];
  logic [8:0]        box_map [9];
  logic              begin_ok;
  logic              accept;
  logic              range_bad;
  logic              given;
  logic              hit;
  logic              cell_ok;
  logic              timeout;
  logic [DIG_W-1:0]  dig_idx;

  assign begin_ok  = i_begin && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign accept    = i_load_valid && (state == ST_LOAD);
  assign range_bad = (i_load_data > 4'd9);
  assign given     = (i_load_data != 4'd0) && !range_bad;
  assign dig_idx   = i_load_data - 4'd1;
  assign cell_ok   = accept && !range_bad && !hit;
  assign timeout   = ((tcnt + 32'd1) == MAX_SOLVE_CYCLES);

  cell_pos_cnt u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (begin_ok || ((state == ST_CLEAR) && last)),
    .en    ((state == ST_CLEAR) || accept),
    .cnt   (cnt),
    .row   (row),
    .col   (col),
    .box   (box),
    .last  (last)
  );

  // Duplicate lookup: digit already present in this row, column or box.
  always_comb begin
    hit = 1'b0;
    if (given) begin
      hit = row_map[row][dig_idx] | col_map[col][dig_idx] | box_map[box][dig_idx];
    end else begin
      hit = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (begin_ok) next_state = ST_CLEAR; else next_state = ST_IDLE;
      ST_CLEAR: if (last) next_state = ST_LOAD; else next_state = ST_CLEAR;
      ST_LOAD: begin
        if (accept && (range_bad || hit)) next_state = ST_ERR;
        else if (accept && last)          next_state = ST_START;
        else                              next_state = ST_LOAD;
      end
      ST_START: next_state = ST_SOLVE;
      ST_SOLVE: begin
        if (i_solver_done) next_state = ST_DONE;
        else if (timeout)  next_state = ST_ERR;
        else               next_state = ST_SOLVE;
      end
      ST_DONE:  if (begin_ok) next_state = ST_CLEAR; else next_state = ST_DONE;
      ST_ERR:   if (begin_ok) next_state = ST_CLEAR; else next_state = ST_ERR;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State register and status flags; flags follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      o_busy       <= 1'b0;
      o_load_ready <= 1'b0;
      o_start      <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= ERR_NONE;
    end else begin
      state        <= next_state;
      o_busy       <= (next_state == ST_CLEAR) || (next_state == ST_LOAD) ||
                      (next_state == ST_START) || (next_state == ST_SOLVE);
      o_load_ready <= (next_state == ST_LOAD);
      o_start      <= (next_state == ST_START);
      if (begin_ok) begin
        o_done  <= 1'b0;
        o_error <= ERR_NONE;
      end else if (accept && range_bad) begin
        o_error <= ERR_RANGE;
      end else if (accept && hit) begin
        o_error <= ERR_DUP;
      end else if ((state == ST_SOLVE) && i_solver_done) begin
        o_done <= 1'b1;
      end else if ((state == ST_SOLVE) && timeout) begin
        o_error <= ERR_TIMEOUT;
      end else begin
        o_done <= o_done;
      end
    end
  end

  // Solver watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 32'd0;
    end else if (state == ST_START) begin
      tcnt <= 32'd0;
    end else if (state == ST_SOLVE) begin
      tcnt <= tcnt + 32'd1;
    end else begin
      tcnt <= tcnt;
    end
  end

  // Memory write port: full wipe during CLEAR, then one write per good cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_we               <= 1'b0;
      o_addr             <= 7'd0;
      o_wrdata           <= 4'd0;
      o_mark_fix         <= 1'b0;
      o_we_mark          <= 1'b0;
      o_mark_value       <= 1'b0;
      o_addr_mark_row    <= 7'd0;
      o_addr_mark_col    <= 7'd0;
      o_addr_mark_matrix <= 7'd0;
    end else begin
      o_we      <= 1'b0;
      o_we_mark <= 1'b0;
      if (state == ST_CLEAR) begin
        o_we               <= 1'b1;
        o_addr             <= cnt;
        o_wrdata           <= 4'd0;
        o_mark_fix         <= 1'b0;
        o_we_mark          <= 1'b1;
        o_mark_value       <= 1'b0;
        o_addr_mark_row    <= cnt;
        o_addr_mark_col    <= cnt;
        o_addr_mark_matrix <= cnt;
      end else if (cell_ok) begin
        o_we       <= 1'b1;
        o_addr     <= cnt;
        o_wrdata   <= i_load_data;
        o_mark_fix <= given;
        if (given) begin
          o_we_mark          <= 1'b1;
          o_mark_value       <= 1'b1;
          o_addr_mark_row    <= mark_addr(row, i_load_data);
          o_addr_mark_col    <= mark_addr(col, i_load_data);
          o_addr_mark_matrix <= mark_addr(box, i_load_data);
        end else begin
          o_we_mark <= 1'b0;
        end
      end else begin
        o_we <= 1'b0;
      end
    end
  end

  // Presence bitmaps mirror the marks written for given digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        row_map[i] <= 9'd0;
        col_map[i] <= 9'd0;
        box_map[i] <= 9'd0;
      end
    end else if (state == ST_CLEAR) begin
      for (int i = 0; i < 9; i++) begin
        row_map[i] <= 9'd0;
        col_map[i] <= 9'd0;
        box_map[i] <= 9'd0;
      end
    end else if (cell_ok && given) begin
      row_map[row][dig_idx] <= 1'b1;
      col_map[col][dig_idx] <= 1'b1;
      box_map[box][dig_idx] <= 1'b1;
    end else begin
      row_map[0] <= row_map[0];
    end
  end

endmodule

// File: tb/tb_puzzle_loader.sv
// Self-checking bench for puzzle_loader: directed vector table, timeout and
// reset sequences, and random puzzles against a sudoku-rule reference model.
module tb_puzzle_loader;

  localparam int MAXC = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_begin, i_load_valid, i_solver_done;
  logic [3:0] i_load_data;
  logic       o_load_ready, o_we, o_mark_fix, o_we_mark, o_mark_value, o_start, o_busy, o_done;
  logic [6:0] o_addr, o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix;
  logic [3:0] o_wrdata;
  logic [1:0] o_error;

  puzzle_loader #(.MAX_SOLVE_CYCLES(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .i_begin(i_begin), .i_load_valid(i_load_valid),
    .i_load_data(i_load_data), .o_load_ready(o_load_ready), .o_we(o_we), .o_addr(o_addr),
    .o_wrdata(o_wrdata), .o_mark_fix(o_mark_fix), .o_we_mark(o_we_mark),
    .o_mark_value(o_mark_value), .o_addr_mark_row(o_addr_mark_row),
    .o_addr_mark_col(o_addr_mark_col), .o_addr_mark_matrix(o_addr_mark_matrix),
    .o_start(o_start), .i_solver_done(i_solver_done), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [3:0] data;
    logic       fix;
    logic       wm;
    logic       mv;
    logic [6:0] mr, mc, mb;
  } wr_t;

  typedef struct {
    int ia; logic [3:0] da; int ib; logic [3:0] db;
    int n_drive; logic [1:0] exp_err; int exp_wr;
    int ma_r, ma_c, ma_b, mb_r, mb_c, mb_b;
  } vec_t;

  wr_t        wq[$];
  logic [3:0] pz [81];
  int         n_chk = 0;
  int         n_fail = 0;

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_we || o_we_mark)
      wq.push_back({o_we, o_addr, o_wrdata, o_mark_fix, o_we_mark, o_mark_value,
                    o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix});
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: walk the cells, stop at the first out-of-range or repeated digit.
  function automatic void model_run(output int n, output logic [1:0] err);
    bit rs [9][10];
    bit cs [9][10];
    bit bs [9][10];
    int r, c, b, d;
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < 10; k++) begin rs[i][k] = 0; cs[i][k] = 0; bs[i][k] = 0; end
    n = 81;
    err = 2'd0;
    for (int i = 0; i < 81; i++) begin
      r = i / 9; c = i % 9; b = (r / 3) * 3 + c / 3; d = int'(pz[i]);
      if (d > 9) begin n = i + 1; err = 2'd1; return; end
      if (d != 0) begin
        if (rs[r][d] || cs[c][d] || bs[b][d]) begin n = i + 1; err = 2'd2; return; end
        rs[r][d] = 1; cs[c][d] = 1; bs[b][d] = 1;
      end
    end
  endfunction

  task automatic gen(input int kind);
    int r, c, sol;
    for (int i = 0; i < 81; i++) begin
      r = i / 9; c = i % 9;
      sol = ((r * 3 + r / 3 + c) % 9) + 1;
      if (kind == 1) pz[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 9)) : 4'd0;
      else           pz[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'(sol);
    end
    if (kind == 2) pz[$urandom_range(0, 80)] = 4'($urandom_range(10, 15));
  endtask

  task automatic do_begin();
    int t;
    wq.delete();
    i_begin = 1'b1;
    step();
    i_begin = 1'b0;
    chk("begin_busy", o_busy, 1);
    chk("begin_status", {o_done, o_error}, 0);
    t = 0;
    while (!o_load_ready && t < 100) begin step(); t++; end
    chk("clear_to_ready", o_load_ready, 1);
    chk("clear_count", wq.size(), 81);
    for (int j = 0; j < 81 && j < wq.size(); j++)
      chk("clear_write", wq[j], {1'b1, 7'(j), 4'd0, 1'b0, 1'b1, 1'b0, 7'(j), 7'(j), 7'(j)});
    wq.delete();
  endtask

  task automatic drive_cells(input int n, input bit rnd);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      acc = 0; tries = 0;
      while (!acc) begin
        i_load_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        i_load_data  = pz[i];
        i_begin      = rnd && ($urandom_range(0, 7) == 0);
        acc = i_load_valid && o_load_ready;
        step();
        tries++;
        if (!acc && tries > 30) begin
          chk("cell_accept_timeout", i, 999);
          i_load_valid = 1'b0; i_begin = 1'b0;
          return;
        end
      end
    end
    i_load_valid = 1'b0;
    i_begin = 1'b0;
  endtask

  task automatic load_tail(input logic [1:0] exp_err);
    if (exp_err == 2'd0) begin
      chk("start_pulse", {o_start, o_busy, o_load_ready}, 3'b110);
      step();
      chk("start_one_cycle", {o_start, o_busy}, 2'b01);
    end else begin
      chk("error_code", o_error, exp_err);
      chk("error_idle", {o_load_ready, o_busy, o_start, o_done}, 0);
    end
  endtask

  task automatic check_writes(input int n_wr);
    int r, c, b, d;
    chk("write_count", wq.size(), n_wr);
    for (int j = 0; j < n_wr && j < wq.size(); j++) begin
      r = j / 9; c = j % 9; b = (r / 3) * 3 + c / 3; d = int'(pz[j]);
      chk("cell_addr_data", {wq[j].we, wq[j].addr, wq[j].data}, {1'b1, 7'(j), 4'(d)});
      chk("cell_fix_wm", {wq[j].fix, wq[j].wm}, {d != 0, d != 0});
      if (d != 0)
        chk("cell_marks", {wq[j].mv, wq[j].mr, wq[j].mc, wq[j].mb},
            {1'b1, 7'(r * 9 + d - 1), 7'(c * 9 + d - 1), 7'(b * 9 + d - 1)});
    end
  endtask

  task automatic finish_solve(input int delay);
    for (int k = 0; k < delay; k++) begin
      i_begin = (k == 0);
      step();
    end
    i_begin = 1'b0;
    i_solver_done = 1'b1;
    step();
    i_solver_done = 1'b0;
    chk("solve_done", {o_done, o_error, o_busy}, 4'b1000);
  endtask

  task automatic find_marks(input string name, input int idx, input logic [3:0] dv,
                            input int mr, input int mc, input int mb);
    bit found = 0;
    foreach (wq[j])
      if (wq[j].addr == 7'(idx) && !found) begin
        found = 1;
        chk(name, {wq[j].data, wq[j].fix, wq[j].wm, wq[j].mv, wq[j].mr, wq[j].mc, wq[j].mb},
            {dv, 3'b111, 7'(mr), 7'(mc), 7'(mb)});
      end
    if (!found) chk(name, 0, 1);
  endtask

  vec_t vecs [7];
  int   n_exp;
  logic [1:0] e_exp;

  initial begin
    vecs[0] = '{0, 4'd5, 80, 4'd9, 81, 2'd0, 81, 4, 4, 4, 80, 80, 80};
    vecs[1] = '{0, 4'd3, 8, 4'd3, 9, 2'd2, 8, 2, 2, 2, 0, 0, 0};
    vecs[2] = '{0, 4'd3, 36, 4'd3, 37, 2'd2, 36, 2, 2, 2, 0, 0, 0};
    vecs[3] = '{0, 4'd3, 10, 4'd3, 11, 2'd2, 10, 2, 2, 2, 0, 0, 0};
    vecs[4] = '{1, 4'hA, 5, 4'd1, 2, 2'd1, 1, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{40, 4'd7, 44, 4'd2, 81, 2'd0, 81, 42, 42, 42, 37, 73, 46};
    vecs[6] = '{0, 4'd9, 80, 4'd9, 81, 2'd0, 81, 8, 8, 8, 80, 80, 80};

    rst_n = 1'b0; i_begin = 1'b0; i_load_valid = 1'b0; i_load_data = 4'd0; i_solver_done = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {o_load_ready, o_we, o_addr, o_wrdata, o_mark_fix, o_we_mark, o_mark_value,
                          o_addr_mark_row, o_addr_mark_col, o_addr_mark_matrix, o_start, o_busy,
                          o_done, o_error}, 0);
    rst_n = 1'b1;
    step();

    // Directed vectors
    foreach (vecs[v]) begin
      for (int i = 0; i < 81; i++) pz[i] = 4'd0;
      pz[vecs[v].ia] = vecs[v].da;
      pz[vecs[v].ib] = vecs[v].db;
      do_begin();
      drive_cells(vecs[v].n_drive, 0);
      load_tail(vecs[v].exp_err);
      chk("vec_write_count", wq.size(), vecs[v].exp_wr);
      if (vecs[v].exp_wr > vecs[v].ia)
        find_marks("vec_marks_a", vecs[v].ia, vecs[v].da, vecs[v].ma_r, vecs[v].ma_c, vecs[v].ma_b);
      if (vecs[v].exp_wr > vecs[v].ib)
        find_marks("vec_marks_b", vecs[v].ib, vecs[v].db, vecs[v].mb_r, vecs[v].mb_c, vecs[v].mb_b);
      if (vecs[v].exp_err == 2'd0) finish_solve($urandom_range(1, 20));
    end

    // Watchdog: expires after MAXC solve cycles; done on the last cycle still wins
    for (int pass = 0; pass < 2; pass++) begin
      gen(0);
      do_begin();
      drive_cells(81, 0);
      load_tail(2'd0);
      repeat (MAXC - 1) step();
      chk("timeout_not_yet", {o_error, o_busy}, 3'b001);
      if (pass == 1) i_solver_done = 1'b1;
      step();
      i_solver_done = 1'b0;
      if (pass == 0) chk("timeout_error", {o_error, o_busy, o_done}, {2'd3, 1'b0, 1'b0});
      else           chk("done_beats_timeout", {o_error, o_busy, o_done}, {2'd0, 1'b0, 1'b1});
    end

    // Random puzzles against the reference model
    for (int t = 0; t < 15; t++) begin
      gen(t % 3);
      model_run(n_exp, e_exp);
      do_begin();
      drive_cells(n_exp, 1);
      load_tail(e_exp);
      check_writes((e_exp == 2'd0) ? n_exp : n_exp - 1);
      if (e_exp == 2'd0) finish_solve($urandom_range(1, 40));
    end

    // Asynchronous reset in the middle of a load, then a clean reload
    gen(0);
    model_run(n_exp, e_exp);
    do_begin();
    drive_cells(40, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {o_load_ready, o_we, o_addr, o_wrdata, o_mark_fix, o_we_mark,
                                   o_mark_value, o_addr_mark_row, o_addr_mark_col,
                                   o_addr_mark_matrix, o_start, o_busy, o_done, o_error}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("after_reset_idle", {o_load_ready, o_busy, o_we}, 0);
    do_begin();
    drive_cells(n_exp, 1);
    load_tail(e_exp);
    check_writes(n_exp);
    finish_solve(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
